// File: rtl/wm_pkg.sv
// Shared types and helpers for the Avalon write master.
package wm_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Number of byte-offset bits covered by one data word.
    function automatic int unsigned lsb_bits(input int unsigned bew);
        return $clog2(bew);
    endfunction

endpackage

// File: rtl/wm_fifo.sv
// Synchronous user-data FIFO; pushes while full are dropped, pops while empty ignored.
module wm_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  data_i,
    output logic [W-1:0]  data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q, count_d;
    logic          full_q;
    logic          do_push, do_pop;

    assign do_push = push_i & ~full_q;
    assign do_pop  = pop_i & (count_q != '0);
    assign count_d = count_q + CW'(do_push) - CW'(do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            if (do_push) wr_q <= wr_q + PW'(1);
            if (do_pop)  rd_q <= rd_q + PW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_q];
    assign full_o  = full_q;
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/avalon_write_master.sv
// Avalon-MM single-word write master fed from a user data FIFO.
// Optional AVALON_WRITE_MASTER_OVERFLOW_EN adds a sticky dropped-push flag.
module avalon_write_master
    import wm_pkg::*;
#(
    parameter int ADDRESSWIDTH    = 28,
    parameter int DATAWIDTH       = 32,
    parameter int BYTEENABLEWIDTH = 4,
    parameter int FIFODEPTH       = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       control_fixed_location,
    input  logic [ADDRESSWIDTH-1:0]    control_write_base,
    input  logic [ADDRESSWIDTH-1:0]    control_write_length,
    input  logic                       control_go,
    output logic                       control_done,
    input  logic                       user_write_buffer,
    input  logic [DATAWIDTH-1:0]       user_buffer_data,
    output logic                       user_buffer_full,
    output logic                       user_overflow,
    output logic [ADDRESSWIDTH-1:0]    master_address,
    output logic                       master_write,
    output logic [BYTEENABLEWIDTH-1:0] master_byteenable,
    output logic [DATAWIDTH-1:0]       master_writedata,
    input  logic                       master_waitrequest
);

    localparam int unsigned LSB = lsb_bits(BYTEENABLEWIDTH);
    localparam logic [ADDRESSWIDTH-1:0] STEP = ADDRESSWIDTH'(1) << LSB;
    localparam int CW = $clog2(FIFODEPTH) + 1;

    state_t                  state_q, state_d;
    logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
    logic [ADDRESSWIDTH-1:0] rem_q, rem_d;
    logic                    fixed_q, fixed_d;
    logic                    done_q, done_d;

    logic                    fifo_full, fifo_empty;
    logic [CW-1:0]           fifo_count;
    logic [DATAWIDTH-1:0]    fifo_head;
    logic                    accept;
    logic [ADDRESSWIDTH-1:0] len_aligned;

    wm_fifo #(
        .W     (DATAWIDTH),
        .DEPTH (FIFODEPTH)
    ) u_fifo (
        .clk_i   (clk),
        .rst_i   (reset),
        .push_i  (user_write_buffer),
        .pop_i   (accept),
        .data_i  (user_buffer_data),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign len_aligned  = control_write_length & ~(STEP - ADDRESSWIDTH'(1));
    assign master_write = (state_q == RUN) && (fifo_count != '0);
    assign accept       = master_write & ~master_waitrequest & ~fifo_empty;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        fixed_d = fixed_q;
        done_d  = done_q;
        case (state_q)
            IDLE: begin
                if (control_go) begin
                    // Sub-word lengths carry nothing to write, so complete at once.
                    if (len_aligned == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = RUN;
                        addr_d  = control_write_base;
                        rem_d   = len_aligned;
                        fixed_d = control_fixed_location;
                        done_d  = 1'b0;
                    end
                end
            end
            RUN: begin
                if (accept) begin
                    rem_d = rem_q - STEP;
                    if (!fixed_q) addr_d = addr_q + STEP;
                    if (rem_q == STEP) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            fixed_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            fixed_q <= fixed_d;
            done_q  <= done_d;
        end
    end

`ifdef AVALON_WRITE_MASTER_OVERFLOW_EN
    logic ovf_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                                ovf_q <= 1'b0;
        else if (user_write_buffer && fifo_full)  ovf_q <= 1'b1;
    end

    assign user_overflow = ovf_q;
`else
    assign user_overflow = 1'b0;
`endif

    assign control_done      = done_q;
    assign user_buffer_full  = fifo_full;
    assign master_address    = addr_q;
    assign master_byteenable = '1;
    assign master_writedata  = fifo_head;

endmodule
